// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mul_pkg;

  localparam int unsigned DEFAULT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    ITER,
    FIX,
    DONE
  } state_t;

  // Width of the iteration counter: must hold values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Sequencer for seq_multiplier: state machine plus iteration counter.
// Emits one-cycle datapath strobes. ABS/FIX are only reachable when
// SEQ_MUL_SIGNED_EN is defined.
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load,
  output logic abs_en,
  output logic add_en,
  output logic shift,
  output logic fix_en,
  output logic capture,
  output logic done,
  output logic busy
);

  localparam int unsigned CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t state, state_next;
  logic [CW-1:0] count;

  // State register and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (load)
        count <= '0;
      else if (shift)
        count <= count + CW'(1);
    end
  end

  // Next-state decode and strobe generation.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    abs_en     = 1'b0;
    add_en     = 1'b0;
    shift      = 1'b0;
    fix_en     = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
          state_next = ABS;
`else
          state_next = ITER;
`endif
        end
      end
      ABS: begin
        abs_en     = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        add_en = 1'b1;
        shift  = 1'b1;
        if (count == LAST) begin
`ifdef SEQ_MUL_SIGNED_EN
          state_next = FIX;
`else
          // Product is captured from the final shift so it is valid in DONE.
          capture    = 1'b1;
          state_next = DONE;
`endif
        end
      end
      FIX: begin
        fix_en     = 1'b1;
        capture    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Busy in every state except IDLE.
  always_comb busy = (state != IDLE);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands and product.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  logic load, abs_en, add_en, shift, fix_en, capture;

  logic [W-1:0]   m_reg, q_reg;
  logic [W:0]     a_reg, sum;
  logic           sign;
  logic [2*W-1:0] mag, res_next;
  logic           ovf_next;

  seq_mul_ctrl #(.W(W)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .load    (load),
    .abs_en  (abs_en),
    .add_en  (add_en),
    .shift   (shift),
    .fix_en  (fix_en),
    .capture (capture),
    .done    (done),
    .busy    (busy)
  );

  // Adder, final-result selection and overflow detection.
  always_comb begin
    sum = a_reg + ((add_en && q_reg[0]) ? {1'b0, m_reg} : '0);
    mag = {a_reg[W-1:0], q_reg};
    // Without FIX the last iteration's shifted {A,Q} is the product.
    res_next = fix_en ? (sign ? -mag : mag) : {sum, q_reg[W-1:1]};
`ifdef SEQ_MUL_SIGNED_EN
    ovf_next = ~((&res_next[2*W-1:W-1]) | ~(|res_next[2*W-1:W-1]));
`else
    ovf_next = |res_next[2*W-1:W];
`endif
  end

  // Datapath registers: operand load, magnitude, shift-add, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      q_reg   <= '0;
      a_reg   <= '0;
      sign    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      if (load) begin
        m_reg <= a_in;
        q_reg <= b_in;
        a_reg <= '0;
        sign  <= 1'b0;
      end else if (abs_en) begin
        m_reg <= m_reg[W-1] ? -m_reg : m_reg;
        q_reg <= q_reg[W-1] ? -q_reg : q_reg;
        sign  <= m_reg[W-1] ^ q_reg[W-1];
      end else if (shift) begin
        a_reg <= {1'b0, sum[W:1]};
        q_reg <= {sum[0], q_reg[W-1:1]};
      end
      if (capture) begin
        product <= res_next;
        ovf     <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (W=6).
module tb_seq_multiplier;

  localparam int W = 6;
`ifdef SEQ_MUL_SIGNED_EN
  localparam int LAT = W + 3;
`else
  localparam int LAT = W + 1;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a_in, b_in;
  logic [2*W-1:0] product;
  logic           busy, done, ovf;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .product (product),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for the product and overflow flag.
  function automatic void golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [2*W-1:0] p, output logic o);
    int pr;
`ifdef SEQ_MUL_SIGNED_EN
    pr = int'($signed(a)) * int'($signed(b));
    o  = (pr < -(1 << (W - 1))) || (pr > (1 << (W - 1)) - 1);
`else
    pr = int'(a) * int'(b);
    o  = (pr >= (1 << W));
`endif
    p = pr[2*W-1:0];
  endfunction

  // Transaction-level model: remaining cycles of the current operation.
  int             phase = 0;
  logic [W-1:0]   opa = '0, opb = '0;
  logic [2*W-1:0] exp_prod = '0;
  logic           exp_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    = 0;
      exp_prod = '0;
      exp_ovf  = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase = LAT;
        opa   = a_in;
        opb   = b_in;
      end
    end else begin
      phase--;
      if (phase == 1) golden(opa, opb, exp_prod, exp_ovf);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("busy", 32'(busy), 32'(phase > 0));
      chk("done", 32'(done), 32'(phase == 1));
      chk("product", 32'(product), 32'(exp_prod));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
    end
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           o;
  } vec_t;

  vec_t vecs[5];

  // Launch one operation, optionally pulsing start at cycles p1/p2 while busy.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] ep, input logic eo, input int p1, input int p2);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    cyc   = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == p1) || (cyc == p2);
    end
    start = 1'b0;
    chk({name, "_latency"}, 32'(cyc), 32'(LAT));
    chk({name, "_product"}, 32'(product), 32'(ep));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
`ifdef SEQ_MUL_SIGNED_EN
    vecs[0] = '{6'h3C, 6'd7, 12'hFE4, 1'b0};   // -4 * 7 = -28
    vecs[1] = '{6'h3B, 6'd7, 12'hFDD, 1'b1};   // -5 * 7 = -35
    vecs[2] = '{6'h20, 6'h20, 12'h400, 1'b1};  // -32 * -32 = 1024
    vecs[3] = '{6'h20, 6'd1, 12'hFE0, 1'b0};   // -32 * 1 = -32
    vecs[4] = '{6'd1, 6'd1, 12'd1, 1'b0};
`else
    vecs[0] = '{6'd13, 6'd11, 12'd143, 1'b1};
    vecs[1] = '{6'd7, 6'd9, 12'd63, 1'b0};
    vecs[2] = '{6'd0, 6'd45, 12'd0, 1'b0};
    vecs[3] = '{6'd63, 6'd63, 12'hF81, 1'b1};
    vecs[4] = '{6'd1, 6'd1, 12'd1, 1'b0};
`endif
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset_product", 32'(product), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Consecutive operations, each restarted the cycle after done.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o, 0, 0);

    // Starts while busy are ignored.
    run_op("ignore", 6'd13, 6'd11, 12'd143, 1'b1, 2, 4);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    a_in  = 6'd9;
    b_in  = 6'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_product", 32'(product), 32'd0);
    chk("async_ovf", 32'(ovf), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 6'd5, 6'd6, 12'd30, 1'b0, 0, 0);

    // Start held high: operations repeat back to back.
    @(negedge clk);
    start = 1'b1;
    a_in  = 6'd3;
    b_in  = 6'd5;
    repeat (2 * (LAT + 1)) @(negedge clk);
    start = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("held_product", 32'(product), 32'd15);
    chk("held_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
